// File: rtl/mm_pkg.sv
// Shared defaults, FSM state encoding and sizing helper for the matrix-multiply stream controller.
package mm_pkg;

    localparam int unsigned MM_DATA_WIDTH   = 8;
    localparam int unsigned MM_N            = 4;
    localparam int unsigned MM_C_DATA_WIDTH = 2 * MM_DATA_WIDTH + $clog2(MM_N);

    typedef enum logic [2:0] {
        LOAD  = 3'd0,
        CLR   = 3'd1,
        FEED  = 3'd2,
        FLUSH = 3'd3,
        DRAIN = 3'd4
    } mm_state_e;

    // Counter width able to address 'depth' entries; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mm_operand_buffer.sv
// Operand store: A then B written row-major by load index; reads column k of A and row k of B.
module mm_operand_buffer
    import mm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = MM_DATA_WIDTH,
    parameter int unsigned N          = MM_N,
    parameter int unsigned AW         = cnt_width(2 * N * N),
    parameter int unsigned KW         = cnt_width(N)
) (
    input  logic                         clk_i,
    input  logic                         reset_ni,
    input  logic                         wr_en_i,
    input  logic [AW-1:0]                wr_addr_i,
    input  logic [DATA_WIDTH-1:0]        wr_data_i,
    input  logic [KW-1:0]                rd_k_i,
    output logic [N-1:0][DATA_WIDTH-1:0] col_a_o,
    output logic [N-1:0][DATA_WIDTH-1:0] row_b_o
);

    localparam int unsigned DEPTH = 2 * N * N;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Operand write port; reset discards any partially loaded job.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            mem_q <= '{default: '0};
        end else if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read A[i][k] for every row i and B[k][j] for every column j.
    for (genvar g = 0; g < N; g++) begin : g_rd
        logic [AW-1:0] a_idx;
        logic [AW-1:0] b_idx;
        assign a_idx      = AW'(g * N) + AW'(rd_k_i);
        assign b_idx      = AW'(N * N + g) + AW'(AW'(rd_k_i) * AW'(N));
        assign col_a_o[g] = mem_q[a_idx];
        assign row_b_o[g] = mem_q[b_idx];
    end

endmodule

// File: rtl/mm_stream_controller.sv
// Loads A/B operands from a stream, feeds a systolic array, captures C and drains it row-major.
module mm_stream_controller
    import mm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = MM_DATA_WIDTH,
    parameter int unsigned N            = MM_N,
    parameter int unsigned C_DATA_WIDTH = 2 * DATA_WIDTH + $clog2(N)
) (
    input  logic                             clk_i,
    input  logic                             reset_ni,
    input  logic                             ld_valid_i,
    output logic                             ld_ready_o,
    input  logic [DATA_WIDTH-1:0]            ld_data_i,
    output logic                             arr_reset_o,
    output logic                             arr_valid_o,
    output logic [N-1:0][DATA_WIDTH-1:0]     arr_a_o,
    output logic [N-1:0][DATA_WIDTH-1:0]     arr_b_o,
    input  logic                             arr_valid_i,
    input  logic [N*N-1:0][C_DATA_WIDTH-1:0] arr_c_i,
    output logic                             res_valid_o,
    input  logic                             res_ready_i,
    output logic [C_DATA_WIDTH-1:0]          res_data_o,
    output logic                             res_last_o
);

    localparam int unsigned LW = cnt_width(2 * N * N);
    localparam int unsigned KW = cnt_width(N);
    localparam int unsigned IW = cnt_width(N * N);

    localparam logic [LW-1:0] LD_LAST  = LW'(2 * N * N - 1);
    localparam logic [KW-1:0] K_LAST   = KW'(N - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N * N - 1);

    mm_state_e state_q, state_n;
    logic [LW-1:0] ld_cnt_q, ld_cnt_n;
    logic [KW-1:0] k_q, k_n;
    logic [IW-1:0] idx_q, idx_n;
    logic          ld_fire;
    logic          c_latch;

    logic [N*N-1:0][C_DATA_WIDTH-1:0] c_buf_q;
    logic [N*N-1:0][C_DATA_WIDTH-1:0] c_src;
    logic [N-1:0][DATA_WIDTH-1:0]     col_a;
    logic [N-1:0][DATA_WIDTH-1:0]     row_b;

    // Operand storage, read at the upcoming k so the array drive can be registered.
    mm_operand_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .N          (N),
        .AW         (LW),
        .KW         (KW)
    ) u_operand_buffer (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .wr_en_i    (ld_fire),
        .wr_addr_i  (ld_cnt_q),
        .wr_data_i  (ld_data_i),
        .rd_k_i     (k_n),
        .col_a_o    (col_a),
        .row_b_o    (row_b)
    );

    // Next-state and counter logic.
    always_comb begin
        state_n  = state_q;
        ld_cnt_n = ld_cnt_q;
        k_n      = k_q;
        idx_n    = idx_q;
        ld_fire  = 1'b0;
        c_latch  = 1'b0;
        unique case (state_q)
            LOAD: begin
                if (ld_valid_i && ld_ready_o) begin
                    ld_fire = 1'b1;
                    if (ld_cnt_q == LD_LAST) begin
                        ld_cnt_n = '0;
                        state_n  = CLR;
                    end else begin
                        ld_cnt_n = ld_cnt_q + LW'(1);
                    end
                end
            end
            CLR: begin
                k_n     = '0;
                state_n = FEED;
            end
            FEED: begin
                if (arr_valid_i) begin
                    c_latch = 1'b1;
                    k_n     = '0;
                    idx_n   = '0;
                    state_n = DRAIN;
                end else if (k_q == K_LAST) begin
                    k_n     = '0;
                    state_n = FLUSH;
                end else begin
                    k_n = k_q + KW'(1);
                end
            end
            FLUSH: begin
                if (arr_valid_i) begin
                    c_latch = 1'b1;
                    idx_n   = '0;
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (res_valid_o && res_ready_i) begin
                    if (idx_q == IDX_LAST) begin
                        idx_n   = '0;
                        state_n = LOAD;
                    end else begin
                        idx_n = idx_q + IW'(1);
                    end
                end
            end
            default: begin
                state_n = LOAD;
            end
        endcase
    end

    // Results come from the array word being captured this edge, otherwise from the buffer.
    always_comb begin
        c_src = c_latch ? arr_c_i : c_buf_q;
    end

    // State, counters, result buffer and registered outputs derived from the next state.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= LOAD;
            ld_cnt_q    <= '0;
            k_q         <= '0;
            idx_q       <= '0;
            c_buf_q     <= '0;
            ld_ready_o  <= 1'b0;
            arr_valid_o <= 1'b0;
            arr_a_o     <= '0;
            arr_b_o     <= '0;
            res_valid_o <= 1'b0;
            res_data_o  <= '0;
            res_last_o  <= 1'b0;
        end else begin
            state_q     <= state_n;
            ld_cnt_q    <= ld_cnt_n;
            k_q         <= k_n;
            idx_q       <= idx_n;
            if (c_latch) begin
                c_buf_q <= arr_c_i;
            end
            ld_ready_o  <= (state_n == LOAD);
            arr_valid_o <= (state_n == FEED) || (state_n == FLUSH);
            arr_a_o     <= (state_n == FEED) ? col_a : '0;
            arr_b_o     <= (state_n == FEED) ? row_b : '0;
            res_valid_o <= (state_n == DRAIN);
            res_data_o  <= (state_n == DRAIN) ? c_src[idx_n] : '0;
            res_last_o  <= (state_n == DRAIN) && (idx_n == IDX_LAST);
        end
    end

    // Array clear follows block reset as well as the one-cycle CLR state.
    assign arr_reset_o = !reset_ni || (state_q == CLR);

endmodule

// File: tb/tb_mm_stream_controller.sv
// Directed bench: bench acts as load source, systolic array and result sink.
module tb_mm_stream_controller;
    import mm_pkg::*;

    localparam int unsigned DW  = MM_DATA_WIDTH;
    localparam int unsigned NN  = MM_N;
    localparam int unsigned CW  = MM_C_DATA_WIDTH;
    localparam int unsigned NSQ = NN * NN;

    logic                     clk_i;
    logic                     reset_ni;
    logic                     ld_valid_i;
    logic                     ld_ready_o;
    logic [DW-1:0]            ld_data_i;
    logic                     arr_reset_o;
    logic                     arr_valid_o;
    logic [NN-1:0][DW-1:0]    arr_a_o;
    logic [NN-1:0][DW-1:0]    arr_b_o;
    logic                     arr_valid_i;
    logic [NSQ-1:0][CW-1:0]   arr_c_i;
    logic                     res_valid_o;
    logic                     res_ready_i;
    logic [CW-1:0]            res_data_o;
    logic                     res_last_o;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    mm_stream_controller #(
        .DATA_WIDTH   (DW),
        .N            (NN),
        .C_DATA_WIDTH (CW)
    ) dut (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .ld_valid_i  (ld_valid_i),
        .ld_ready_o  (ld_ready_o),
        .ld_data_i   (ld_data_i),
        .arr_reset_o (arr_reset_o),
        .arr_valid_o (arr_valid_o),
        .arr_a_o     (arr_a_o),
        .arr_b_o     (arr_b_o),
        .arr_valid_i (arr_valid_i),
        .arr_c_i     (arr_c_i),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .res_data_o  (res_data_o),
        .res_last_o  (res_last_o)
    );

    int n_cmp;
    int n_bad;

    logic [DW-1:0]  mat_a [NSQ];
    logic [DW-1:0]  mat_b [NSQ];
    logic [CW-1:0]  exp_c [NSQ];
    logic [CW-1:0]  got_c [NSQ];
    logic [CW-1:0]  acc   [NSQ];
    logic [NSQ-1:0] last_seen;
    int             got_n;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Assert reset mid-cycle, check reset values, release and check ready rises one edge later.
    task automatic pulse_reset();
        reset_ni = 1'b0;
        #1;
        check_eq("rst_ld_ready",  32'(ld_ready_o),  0);
        check_eq("rst_arr_valid", 32'(arr_valid_o), 0);
        check_eq("rst_arr_reset", 32'(arr_reset_o), 1);
        check_eq("rst_arr_a",     32'(arr_a_o),     0);
        check_eq("rst_arr_b",     32'(arr_b_o),     0);
        check_eq("rst_res_valid", 32'(res_valid_o), 0);
        check_eq("rst_res_last",  32'(res_last_o),  0);
        check_eq("rst_res_data",  32'(res_data_o),  0);
        @(negedge clk_i);
        reset_ni = 1'b1;
        #1;
        check_eq("rel_ready_low", 32'(ld_ready_o), 0);
        @(negedge clk_i);
        check_eq("rel_ready_rise", 32'(ld_ready_o), 1);
        check_eq("rel_arr_reset",  32'(arr_reset_o), 0);
    endtask

    // Stream A then B; optional 1-0-1-0 valid pattern, spurious array valids, early stop.
    task automatic load_ops(input bit gaps, input bit junk, input int stop_at);
        int beat = 0;
        int cyc  = 0;
        while (beat < int'(2 * NSQ) && beat != stop_at && cyc < 400) begin
            @(negedge clk_i);
            cyc++;
            ld_valid_i  = gaps ? 1'(cyc % 2) : 1'b1;
            ld_data_i   = (beat < int'(NSQ)) ? mat_a[beat] : mat_b[beat - int'(NSQ)];
            arr_valid_i = junk;
            arr_c_i     = junk ? '1 : '0;
            if (ld_valid_i && ld_ready_o) beat++;
        end
        @(negedge clk_i);
        ld_valid_i  = 1'b0;
        arr_valid_i = 1'b0;
        arr_c_i     = '0;
        if (stop_at < 0) begin
            check_eq("load_beats",    32'(beat), 2 * NSQ);
            check_eq("clr_arr_reset", 32'(arr_reset_o), 1);
            check_eq("clr_arr_valid", 32'(arr_valid_o), 0);
            check_eq("clr_ld_ready",  32'(ld_ready_o), 0);
            for (int e = 0; e < int'(NSQ); e++) acc[e] = '0;
        end
    endtask

    // Behave as the array: accumulate outer products, answer after two flush cycles.
    task automatic array_phase(input int rst_at, output bit aborted);
        int vcnt = 0;
        int cyc  = 0;
        bit done = 1'b0;
        aborted = 1'b0;
        while (!done && cyc < 100) begin
            @(negedge clk_i);
            cyc++;
            if (cyc == 1) check_eq("clr_one_cycle", 32'(arr_reset_o), 0);
            if (arr_valid_o) begin
                if (vcnt == rst_at) begin
                    pulse_reset();
                    aborted = 1'b1;
                    return;
                end
                if (vcnt == 0)  check_eq("feed_ld_ready", 32'(ld_ready_o), 0);
                if (vcnt == int'(NN)) check_eq("flush_zero_a", 32'(arr_a_o), 0);
                for (int i = 0; i < int'(NN); i++)
                    for (int j = 0; j < int'(NN); j++)
                        acc[i*NN + j] += CW'(arr_a_o[i]) * CW'(arr_b_o[j]);
                vcnt++;
                if (vcnt == int'(NN) + 2) begin
                    arr_valid_i = 1'b1;
                    for (int e = 0; e < int'(NSQ); e++) arr_c_i[e] = acc[e];
                    done = 1'b1;
                end
            end
        end
        if (!done) begin
            check_eq("array_timeout", 0, 1);
            return;
        end
        @(negedge clk_i);
        arr_valid_i = 1'b0;
        check_eq("arr_valid_drop", 32'(arr_valid_o), 0);
        check_eq("res_valid_up",   32'(res_valid_o), 1);
        check_eq("drain_ld_ready", 32'(ld_ready_o), 0);
    endtask

    // Sink results; optionally hold ready low for three cycles on one beat.
    task automatic drain(input int stall_beat);
        int cyc   = 0;
        int stall = 0;
        logic [CW-1:0] held;
        held      = '0;
        got_n     = 0;
        last_seen = '0;
        while (got_n < int'(NSQ) && cyc < 200) begin
            @(negedge clk_i);
            cyc++;
            res_ready_i = 1'b1;
            if (got_n == stall_beat && stall < 3) begin
                res_ready_i = 1'b0;
                if (stall == 0) held = res_data_o;
                else check_eq("stall_hold", 32'(res_data_o), 32'(held));
                stall++;
            end
            if (res_valid_o && res_ready_i) begin
                got_c[got_n]     = res_data_o;
                last_seen[got_n] = res_last_o;
                got_n++;
            end
        end
        @(negedge clk_i);
        res_ready_i = 1'b0;
        check_eq("drain_beats",   32'(got_n), NSQ);
        check_eq("post_res_valid", 32'(res_valid_o), 0);
        check_eq("post_ld_ready", 32'(ld_ready_o), 1);
        check_eq("last_only_15",  32'(last_seen), 32'h8000);
        if (stall_beat >= 0) check_eq("stall_value", 32'(held), 32'(exp_c[stall_beat]));
        for (int e = 0; e < got_n; e++) check_eq("res_c", 32'(got_c[e]), 32'(exp_c[e]));
    endtask

    task automatic run_job(input bit gaps, input bit junk, input int stall_beat);
        bit ab;
        load_ops(gaps, junk, -1);
        array_phase(-1, ab);
        drain(stall_beat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1);
    end

    initial begin
        bit ab;
        n_cmp       = 0;
        n_bad       = 0;
        reset_ni    = 1'b0;
        ld_valid_i  = 1'b0;
        ld_data_i   = '0;
        arr_valid_i = 1'b0;
        arr_c_i     = '0;
        res_ready_i = 1'b0;
        for (int e = 0; e < int'(NSQ); e++) acc[e] = '0;
        repeat (2) @(negedge clk_i);
        pulse_reset();

        // Identity times index matrix, stall on beat 5.
        for (int e = 0; e < int'(NSQ); e++) begin
            mat_a[e] = (e / NN == e % NN) ? DW'(1) : DW'(0);
            mat_b[e] = DW'(e);
            exp_c[e] = CW'(e);
        end
        run_job(1'b0, 1'b0, 5);

        // Same job with gapped load and spurious array valids during LOAD.
        run_job(1'b1, 1'b1, -1);

        // Full-scale operands: 4 * 255 * 255.
        for (int e = 0; e < int'(NSQ); e++) begin
            mat_a[e] = DW'(255);
            mat_b[e] = DW'(255);
            exp_c[e] = CW'(260100);
        end
        run_job(1'b0, 1'b0, -1);

        // Abandon a partial load, then a job that is reset at FEED k=2.
        load_ops(1'b0, 1'b0, 10);
        pulse_reset();
        for (int e = 0; e < int'(NSQ); e++) begin
            mat_a[e] = (e / NN == e % NN) ? DW'(1) : DW'(0);
            mat_b[e] = DW'(e);
        end
        load_ops(1'b0, 1'b0, -1);
        array_phase(2, ab);
        check_eq("feed_abort", 32'(ab), 1);

        // Fresh job: diag(2) times index matrix.
        for (int e = 0; e < int'(NSQ); e++) begin
            mat_a[e] = (e / NN == e % NN) ? DW'(2) : DW'(0);
            mat_b[e] = DW'(e);
            exp_c[e] = CW'(2 * e);
        end
        run_job(1'b0, 1'b0, -1);

        // Back-to-back: all-ones times index matrix gives 24 + 4*j.
        for (int e = 0; e < int'(NSQ); e++) begin
            mat_a[e] = DW'(1);
            mat_b[e] = DW'(e);
            exp_c[e] = CW'(24 + 4 * (e % NN));
        end
        run_job(1'b0, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
